// File: rtl/isqrt_pipe.sv
// Pipelined integer square root, y = floor(sqrt(x)), 32-bit radicand to 16-bit root.
// ITER_PER_STAGE restoring iterations per stage; one new x per cycle, no backpressure.
module isqrt_pipe #(
   parameter int ITER_PER_STAGE = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        x_vld,
   input  logic [31:0] x,
   output logic        y_vld,
   output logic [15:0] y
);

   localparam int LATENCY = 16 / ITER_PER_STAGE;

   typedef struct packed {
      logic [17:0] rem;
      logic [15:0] root;
      logic [31:0] rad;
   } sqrt_state_t;

   // One restoring iteration: rem never exceeds 2*root, so 18 bits are always enough.
   function automatic sqrt_state_t sqrt_step(input sqrt_state_t st);
      sqrt_state_t nx;
      if ({st.rem, st.rad[31:30]} >= {2'b00, st.root, 2'b01}) begin
         nx.rem  = 18'({st.rem, st.rad[31:30]} - {2'b00, st.root, 2'b01});
         nx.root = {st.root[14:0], 1'b1};
      end else begin
         nx.rem  = 18'({st.rem, st.rad[31:30]});
         nx.root = {st.root[14:0], 1'b0};
      end
      nx.rad = {st.rad[29:0], 2'b00};
      return nx;
   endfunction

   sqrt_state_t        stage_s [LATENCY];
   sqrt_state_t        pipe_r  [LATENCY];
   sqrt_state_t        cur_s;
   logic [LATENCY-1:0] vld_r;

   // Combinational iteration chain feeding each stage register.
   always_comb begin
      stage_s = '{default: '0};
      cur_s   = '{rem: 18'd0, root: 16'd0, rad: x};
      for (int s = 0; s < LATENCY; s++) begin
         for (int i = 0; i < ITER_PER_STAGE; i++) begin
            cur_s = sqrt_step(cur_s);
         end
         stage_s[s] = cur_s;
         if (s < LATENCY - 1) begin
            cur_s = pipe_r[s];
         end else begin
            cur_s = '0;
         end
      end
   end

   // Data registers load every cycle and carry no reset; validity lives in vld_r.
   always_ff @(posedge clk) begin
      for (int s = 0; s < LATENCY; s++) begin
         pipe_r[s] <= stage_s[s];
      end
   end

   // Valid shift register, cleared by reset so in-flight work never emerges.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_r <= '0;
      end else begin
         vld_r[0] <= x_vld;
         for (int s = 1; s < LATENCY; s++) begin
            vld_r[s] <= vld_r[s-1];
         end
      end
   end

   assign y_vld = vld_r[LATENCY-1];
   assign y     = pipe_r[LATENCY-1].root;

endmodule

// File: tb/tb_isqrt_pipe.sv
// Bench for isqrt_pipe: one shared stimulus drives instances with ITER_PER_STAGE 1,2,4,8,16,
// each with its own in-order scoreboard keyed on the expected output cycle.
module tb_isqrt_pipe;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        x_vld = 1'b0;
   logic [31:0] x = 32'd0;
   logic [15:0] exp_y = 16'd0;
   logic        fin = 1'b0;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   typedef struct {
      logic        vld;
      logic [31:0] x;
      logic [15:0] y;
   } vec_t;

   typedef struct {
      int          due;
      logic [15:0] y;
   } exp_t;

   // Independent reference: bitwise search on r*r <= v.
   function automatic logic [15:0] isqrt_ref(input logic [31:0] v);
      logic [15:0] r;
      logic [15:0] t;
      r = 16'd0;
      for (int b = 15; b >= 0; b--) begin
         t = r | (16'd1 << b);
         if (longint'(t) * longint'(t) <= longint'(v)) r = t;
      end
      return r;
   endfunction

   for (genvar g = 0; g < 5; g++) begin : g_dut
      localparam int IPS = 1 << g;
      localparam int LAT = 16 / IPS;
      logic        y_vld;
      logic [15:0] y;
      exp_t        q[$];
      exp_t        e;
      int          cyc = 0;
      int          in_cnt = 0;
      int          out_cnt = 0;
      bit          armed = 1'b0;
      bit          exp_v;

      isqrt_pipe #(.ITER_PER_STAGE(IPS)) u_dut (
         .clk   (clk),
         .rst   (rst),
         .x_vld (x_vld),
         .x     (x),
         .y_vld (y_vld),
         .y     (y)
      );

      always @(posedge clk) begin
         cyc++;
         if (rst) begin
            in_cnt -= q.size();
            q.delete();
            armed = 1'b1;
         end else if (armed && x_vld) begin
            e.due = cyc + LAT - 1;
            e.y   = exp_y;
            q.push_back(e);
            in_cnt++;
         end
         #1;
         if (armed) begin
            exp_v = (q.size() > 0) && (q[0].due == cyc);
            checks++;
            if (y_vld !== exp_v) begin
               failures++;
               $display("FAIL y_vld ips=%0d cyc=%0d got=%0b exp=%0b", IPS, cyc, y_vld, exp_v);
            end
            if (exp_v) begin
               checks++;
               if (y !== q[0].y) begin
                  failures++;
                  $display("FAIL y ips=%0d cyc=%0d got=%h exp=%h", IPS, cyc, y, q[0].y);
               end
               void'(q.pop_front());
            end
            if (y_vld === 1'b1) out_cnt++;
         end
      end

      initial begin
         wait (fin);
         checks++;
         if (q.size() != 0) begin
            failures++;
            $display("FAIL drain ips=%0d pending=%0d exp=0", IPS, q.size());
         end
         checks++;
         if (out_cnt != in_cnt) begin
            failures++;
            $display("FAIL count ips=%0d y_vld_count=%0d exp=%0d", IPS, out_cnt, in_cnt);
         end
      end
   end

   task automatic drive(input logic v, input logic [31:0] xv, input logic [15:0] yv);
      @(negedge clk);
      x_vld = v;
      x     = xv;
      exp_y = yv;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 32'd0, 16'd0);
   endtask

   vec_t tbl[$];

   initial begin
      logic [31:0] xv;
      logic [15:0] r;
      logic        v;

      // Reset sequence; first, consecutive, and sparse vectors with hand-computed roots.
      tbl = '{
         '{1'b1, 32'd0, 16'd0}, '{1'b1, 32'd1, 16'd1}, '{1'b1, 32'd2, 16'd1}, '{1'b1, 32'd3, 16'd1},
         '{1'b1, 32'd15, 16'd3}, '{1'b1, 32'd16, 16'd4}, '{1'b1, 32'd99, 16'd9},
         '{1'b1, 32'd100, 16'd10}, '{1'b1, 32'hFFFE_0001, 16'hFFFF},
         '{1'b1, 32'hFFFE_0000, 16'hFFFE}, '{1'b1, 32'hFFFF_FFFF, 16'hFFFF},
         '{1'b1, 32'd24, 16'd4}, '{1'b1, 32'd25, 16'd5},
         '{1'b1, 32'h4000_0000, 16'h8000}, '{1'b1, 32'h3FFF_FFFF, 16'h7FFF},
         '{1'b1, 32'd49, 16'd7}, '{1'b0, 32'd0, 16'd0}, '{1'b0, 32'd0, 16'd0},
         '{1'b1, 32'd64, 16'd8}, '{1'b1, 32'd81, 16'd9}, '{1'b0, 32'd0, 16'd0},
         '{1'b1, 32'd121, 16'd11}
      };

      rst = 1'b1;
      idle(3);
      @(negedge clk);
      rst = 1'b0;
      idle(2);
      for (int i = 0; i < tbl.size(); i++) drive(tbl[i].vld, tbl[i].x, tbl[i].y);
      idle(20);

      // Reset five cycles after x=144: it must never emerge.
      drive(1'b1, 32'd144, 16'd12);
      idle(4);
      @(negedge clk);
      rst = 1'b1;
      x_vld = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      idle(20);
      drive(1'b1, 32'd144, 16'd12);
      idle(20);

      // x_vld coinciding with reset is ignored.
      drive(1'b1, 32'd169, 16'd13);
      idle(3);
      @(negedge clk);
      rst   = 1'b1;
      x_vld = 1'b1;
      x     = 32'd144;
      exp_y = 16'd12;
      @(negedge clk);
      rst   = 1'b0;
      x_vld = 1'b0;
      idle(20);

      // Random stream at ~70% density, biased toward perfect squares and their edges.
      for (int i = 0; i < 10000; i++) begin
         v = ($urandom_range(0, 99) < 70);
         r = 16'($urandom_range(0, 65535));
         case ($urandom_range(0, 3))
            0: xv = 32'(r) * 32'(r);
            1: xv = 32'(r) * 32'(r) + 32'(r) * 32'd2;
            default: xv = $urandom;
         endcase
         drive(v, xv, isqrt_ref(xv));
      end
      idle(20);

      @(negedge clk);
      fin = 1'b1;
      @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
